// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared CPU type definitions.
//   hazard_state_t : hazard controller FSM states (RUN, DRAIN, HALTED).
//   CNT_W          : width of the hazard event counters.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  localparam int CNT_W = 16;

endpackage

// File: rtl/hazard_ctrl_sat_cnt.sv
// sat_cnt -- saturating up-counter with synchronous clear.
// Ports:
//   CLK   : clock, counter updates on rising edge
//   clear : synchronous clear to zero (wins over inc)
//   inc   : add one this edge unless already at all-ones
//   count : current registered count
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge CLK) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard / stall / flush controller.
// Ports:
//   CLK, RST                 : clock, synchronous active-high reset
//   ihit, dhit               : instruction fetch / data access completed
//   instr_out_1              : IF/ID instruction (rs=[25:21], rt=[20:16])
//   dREN_out_2, RegWrite_out_2, rt_out_2 : ID/EX load info
//   dREN_out_3, dWEN_out_3   : EX/MEM data access pending
//   beq/bne/zero/j/JR/jal_out_3 : EX/MEM control-transfer flags
//   halt_or_out_3            : halt instruction in EX/MEM
//   pc_en, en_1..en_4        : PC and pipeline bar enables
//   flush_1..flush_3         : bubble insert for bars 1-3
//   halt                     : sticky, registered halt indication
//   stall_cnt, flush_cnt     : saturating load-use / taken-branch counters
module hazard_ctrl
  import cpu_types_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [31:0]      instr_out_1,
  input  logic             dREN_out_2,
  input  logic             RegWrite_out_2,
  input  logic [4:0]       rt_out_2,
  input  logic             dREN_out_3,
  input  logic             dWEN_out_3,
  input  logic             beq_out_3,
  input  logic             bne_out_3,
  input  logic             zero_out_3,
  input  logic             j_out_3,
  input  logic             JR_out_3,
  input  logic             jal_out_3,
  input  logic             halt_or_out_3,
  output logic             pc_en,
  output logic             en_1,
  output logic             en_2,
  output logic             en_3,
  output logic             en_4,
  output logic             flush_1,
  output logic             flush_2,
  output logic             flush_3,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state_q, state_d;
  logic          halt_q, halt_d;
  logic          stall_inc, flush_inc;

  logic [4:0] rs, rt;
  logic       dpend, adv, taken, lu;

  // Only the register specifiers of the IF/ID instruction matter here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_out_1[31:26], instr_out_1[15:0]};

  assign rs    = instr_out_1[25:21];
  assign rt    = instr_out_1[20:16];
  assign dpend = dREN_out_3 | dWEN_out_3;
  // While a data access is outstanding the pipeline advances on dhit, else on ihit.
  assign adv   = dpend ? dhit : ihit;
  assign taken = (beq_out_3 & zero_out_3) | (bne_out_3 & ~zero_out_3) |
                 j_out_3 | JR_out_3 | jal_out_3;
  // Writes to $0 are discarded, so a load into $0 never creates a dependency.
  assign lu    = dREN_out_2 & RegWrite_out_2 & (rt_out_2 != 5'd0) &
                 ((rt_out_2 == rs) | (rt_out_2 == rt));

  always_comb begin
    state_d   = state_q;
    pc_en     = 1'b0;
    en_1      = 1'b0;
    en_2      = 1'b0;
    en_3      = 1'b0;
    en_4      = 1'b0;
    flush_1   = 1'b0;
    flush_2   = 1'b0;
    flush_3   = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    // adv=0 leaves everything frozen; reset forces all controls low.
    if (RST) begin
      state_d = RUN;
    end else if (adv) begin
      unique case (state_q)
        RUN: begin
          if (halt_or_out_3) begin
            // Stop fetching; let the instructions past ID/EX retire.
            state_d = DRAIN;
            en_2    = 1'b1;
            en_3    = 1'b1;
            en_4    = 1'b1;
            flush_1 = 1'b1;
            flush_2 = 1'b1;
          end else if (dpend) begin
            // Data access completes: hold front end, bubble into ID/EX.
            en_2    = 1'b1;
            en_3    = 1'b1;
            en_4    = 1'b1;
            flush_2 = 1'b1;
          end else if (taken) begin
            pc_en     = 1'b1;
            en_1      = 1'b1;
            en_2      = 1'b1;
            en_3      = 1'b1;
            en_4      = 1'b1;
            flush_1   = 1'b1;
            flush_2   = 1'b1;
            flush_3   = 1'b1;
            flush_inc = 1'b1;
          end else if (lu) begin
            // The inserted bubble clears lu next cycle, so this lasts one cycle.
            en_2      = 1'b1;
            en_3      = 1'b1;
            en_4      = 1'b1;
            flush_2   = 1'b1;
            stall_inc = 1'b1;
          end else begin
            pc_en = 1'b1;
            en_1  = 1'b1;
            en_2  = 1'b1;
            en_3  = 1'b1;
            en_4  = 1'b1;
          end
        end
        DRAIN: begin
          state_d = HALTED;
          en_2    = 1'b1;
          en_3    = 1'b1;
          en_4    = 1'b1;
          flush_1 = 1'b1;
          flush_2 = 1'b1;
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end

    halt_d = (state_d == HALTED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign halt = halt_q;

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .clear (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .clear (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 CLK  in  1  Single clock; all state updates on its rising edge.
REQ-002 RST  in  1  Reset; synchronous and active-high.
REQ-003 ihit  in  1  Instruction fetch done this cycle.
REQ-004 dhit  in  1  Data access done this cycle.
REQ-005 instr_out_1  in  32  IF/ID instruction; rs=[25:21], rt=[20:16].
REQ-006 dREN_out_2, RegWrite_out_2  in  1 each  ID/EX load and register-write flags.
REQ-007 rt_out_2  in  5  ID/EX load destination.
REQ-008 dREN_out_3, dWEN_out_3  in  1 each  EX/MEM data access pending.
REQ-009 beq_out_3, bne_out_3, zero_out_3, j_out_3, JR_out_3, jal_out_3  in  1 each  EX/MEM control-transfer flags.
REQ-010 halt_or_out_3  in  1  Halt instruction is in EX/MEM.
REQ-011 pc_en  out  1  PC load enable.
REQ-012 en_1..en_4  out  1 each  Pipeline register bar enables.
REQ-013 flush_1..flush_3  out  1 each  Bubble insert for bars 1-3; a flush wins over its enable.
REQ-014 halt  out  1  Sticky halt indication.
REQ-015 stall_cnt, flush_cnt  out  16 each  Saturating event counters.

Function
REQ-016 Define the following terms:
- dpend = dREN_out_3 | dWEN_out_3.
- adv = dpend ? dhit : ihit.
- taken = (beq_out_3 & zero_out_3) | (bne_out_3 & ~zero_out_3) | j_out_3 | JR_out_3 | jal_out_3.
- lu = dREN_out_2 & RegWrite_out_2 & (rt_out_2 != 0) & (rt_out_2 == rs | rt_out_2 == rt).
REQ-017 The FSM has three states: RUN, DRAIN and HALTED.
REQ-018 In any state with adv=0, all outputs except counters and halt are 0 (freeze), and the state holds.
REQ-019 RUN, adv=1, dpend=1 (dhit cycle): pc_en=0, en_1=0, flush_2=1, en_2..4=1.
REQ-020 RUN, adv=1, taken=1: pc_en=1, en_1..4=1, flush_1=flush_2=flush_3=1; flush_cnt += 1.
REQ-021 RUN, adv=1, taken=0, lu=1: pc_en=0, en_1=0, flush_2=1, en_2..4=1; stall_cnt += 1.
REQ-022 Priority in RUN is freeze > dhit cycle > taken > lu > normal; normal means pc_en=1, en_1..4=1, no flush.
REQ-023 A load-use stall lasts exactly one cycle, because the bubble clears lu on the following cycle.
REQ-024 RUN to DRAIN occurs on adv=1 with halt_or_out_3=1; this has priority over taken and lu.
REQ-025 In that transition cycle and in DRAIN, pc_en=0, en_1=0, flush_1=1, flush_2=1, en_3=en_4=1.
REQ-026 DRAIN to HALTED occurs on the next adv=1 cycle.
REQ-027 In HALTED: all enables and flushes are 0 and halt=1; the state is left only by RST.
REQ-028 Counters saturate at 16'hFFFF and never wrap.
REQ-029 Counters increment only on cycles where their event is actually applied.
REQ-030 All outputs except counters and halt are combinational from state and inputs; state, counters and halt are registered.

Reset
REQ-031 While RST=1 at a clock edge, the following take effect at that edge:
- state <= RUN.
- stall_cnt <= 0, flush_cnt <= 0.
- halt <= 0.
REQ-032 While RST=1, pc_en, en_* and flush_* are forced to 0.
REQ-033 A reset asserted mid-stall or in DRAIN/HALTED returns the block to RUN on the next edge with no residual bubble.

Structure
REQ-034 hazard_state_t (RUN, DRAIN, HALTED) and CNT_W=16 shall be added to cpu_types_pkg.
REQ-035 One sub-module sat_cnt (width parameter, inc, clear, count) shall be instantiated twice.
REQ-036 The block shall target 150-250 lines of RTL.

Verification
REQ-037 Load-use: lw $3 in ID/EX with rt_out_2=3, IF/ID add $4,$3,$5, ihit=1.
- Cycle 1: pc_en=0, en_1=0, flush_2=1; stall_cnt=1.
- Cycle 2: normal.
REQ-038 Taken beq: beq_out_3=1, zero_out_3=1, lu also true, ihit=1.
- flush_1..3=1 and pc_en=1.
- flush_cnt=1, stall_cnt unchanged.
REQ-039 Data wait: dREN_out_3=1, dhit=0 for 3 cycles, then dhit=1.
- First 3 cycles: all en=0.
- Fourth cycle: en_1=0, flush_2=1, en_2..4=1.
REQ-040 Halt: halt_or_out_3=1, ihit=1.
- Next state DRAIN, pc_en=0.
- After one more adv cycle: HALTED, halt=1, all en=0.
- RST=1 returns to RUN with halt=0.
REQ-041 Saturation: stall_cnt preset near max via 65,536 load-use events → stall_cnt holds 16'hFFFF.
REQ-042 Register $0: lw $0 with IF/ID reading $0 → no stall, stall_cnt unchanged.
